// File: rtl/rtr_ovc_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rtr_ovc_alloc_ctrl
// Purpose  : Output-VC allocation controller for one router output port.
//            Tracks the busy/free state of every output VC. Allocates free
//            VCs to competing input VCs with a separable, single-pass
//            allocator:
//              stage 1 - each free output VC offers itself to one eligible
//                        requester, chosen round-robin from its own pointer.
//              stage 2 - each requester accepts the lowest-indexed offer.
//            A VC returns to FREE when its tail flit has left, which is
//            signalled by ovc_release.
// Ports    : clk          - clock; all state changes on the rising edge
//            rst_n        - asynchronous active-low reset
//            req          - per-requester allocation request
//            req_ovc_mask - candidate output VCs per requester, requester-major
//                           (bit r*NUM_OVCS + o)
//            ovc_release  - per-VC release pulse (tail flit sent)
//            gnt          - registered one-cycle grant strobe per requester
//            gnt_ovc      - one-hot granted VC per requester, valid with gnt
//            ovc_busy     - current allocation state per output VC
//            errors       - [0] request with empty mask, [1] release of a
//                           free VC; registered
// Revision : 1.0 - initial release
// ============================================================================
module rtr_ovc_alloc_ctrl #(
    parameter int NUM_REQUESTERS       = 4,
    parameter int NUM_MESSAGE_CLASSES  = 2,
    parameter int NUM_RESOURCE_CLASSES = 2,
    parameter int NUM_VCS_PER_CLASS    = 1,
    // ovc index = (mc*NUM_RESOURCE_CLASSES + rc)*NUM_VCS_PER_CLASS + v
    parameter int NUM_OVCS             = NUM_MESSAGE_CLASSES * NUM_RESOURCE_CLASSES * NUM_VCS_PER_CLASS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQUESTERS-1:0]           req,
    input  logic [NUM_REQUESTERS*NUM_OVCS-1:0]  req_ovc_mask,
    input  logic [NUM_OVCS-1:0]                 ovc_release,
    output logic [NUM_REQUESTERS-1:0]           gnt,
    output logic [NUM_REQUESTERS*NUM_OVCS-1:0]  gnt_ovc,
    output logic [NUM_OVCS-1:0]                 ovc_busy,
    output logic [0:1]                          errors
);

    localparam int c_PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_OVCS-1:0]                     r_busy;
    logic [NUM_OVCS-1:0][c_PTR_W-1:0]        r_ptr;
    logic [NUM_REQUESTERS-1:0]               r_gnt;
    logic [NUM_REQUESTERS*NUM_OVCS-1:0]      r_gnt_ovc;
    logic [0:1]                              r_errors;

    // ------------------------------------------------------------------------
    // Combinational allocator signals
    // ------------------------------------------------------------------------
    logic [NUM_OVCS-1:0][NUM_REQUESTERS-1:0] w_elig;       // [ovc][req]
    logic [NUM_OVCS-1:0][NUM_REQUESTERS-1:0] w_offer;      // one-hot per ovc
    logic [NUM_OVCS-1:0][c_PTR_W-1:0]        w_offer_idx;  // index of offered req
    logic [NUM_REQUESTERS-1:0][NUM_OVCS-1:0] w_accept;     // [req][ovc]
    logic [NUM_OVCS-1:0]                     w_ovc_won;
    logic [NUM_REQUESTERS-1:0]               w_req_won;
    logic [NUM_REQUESTERS-1:0]               w_req_empty;
    logic                                    w_err_empty;
    logic                                    w_err_release;

    // Pointer wraps to zero after the last requester.
    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        if (int'(p) >= NUM_REQUESTERS - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // Eligibility. A requester whose grant is currently visible is masked,
    // because it still holds req during that cycle and must not be granted
    // a second VC for the same packet.
    // ------------------------------------------------------------------------
    for (genvar o = 0; o < NUM_OVCS; o++) begin : g_elig_ovc
        for (genvar r = 0; r < NUM_REQUESTERS; r++) begin : g_elig_req
            assign w_elig[o][r] = req[r]
                                & req_ovc_mask[r*NUM_OVCS + o]
                                & ~r_busy[o]
                                & ~r_gnt[r];
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: each VC scans requesters starting at its pointer and offers
    // itself to the first eligible one. Busy VCs have no eligible requesters,
    // so they never offer.
    // ------------------------------------------------------------------------
    always_comb begin
        int   idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        w_offer     = '0;
        w_offer_idx = '0;
        for (int o = 0; o < NUM_OVCS; o++) begin
            found = 1'b0;
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                idx = (int'(r_ptr[o]) + i) % NUM_REQUESTERS;
                if (!found && w_elig[o][idx]) begin
                    found             = 1'b1;
                    w_offer[o][idx]   = 1'b1;
                    w_offer_idx[o]    = c_PTR_W'(idx);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: each requester keeps only its lowest-indexed offer. Offers
    // that are not accepted are simply lost for this cycle; the VC stays
    // FREE and its pointer does not move.
    // ------------------------------------------------------------------------
    always_comb begin
        logic taken;
        taken    = 1'b0;
        w_accept = '0;
        for (int r = 0; r < NUM_REQUESTERS; r++) begin
            taken = 1'b0;
            for (int o = 0; o < NUM_OVCS; o++) begin
                if (!taken && w_offer[o][r]) begin
                    taken          = 1'b1;
                    w_accept[r][o] = 1'b1;
                end
            end
        end
    end

    // A VC is won when its single offer was accepted by the chosen requester.
    always_comb begin
        w_ovc_won = '0;
        for (int r = 0; r < NUM_REQUESTERS; r++) begin
            for (int o = 0; o < NUM_OVCS; o++) begin
                w_ovc_won[o] = w_ovc_won[o] | w_accept[r][o];
            end
        end
    end

    for (genvar r = 0; r < NUM_REQUESTERS; r++) begin : g_req_summary
        assign w_req_won[r]   = |w_accept[r];
        assign w_req_empty[r] = req[r] & ~|req_ovc_mask[r*NUM_OVCS +: NUM_OVCS];
    end

    assign w_err_empty   = |w_req_empty;
    // Releasing a VC that is already FREE is a protocol error; the state
    // is left unchanged.
    assign w_err_release = |(ovc_release & ~r_busy);

    // ------------------------------------------------------------------------
    // Registers. Grants only ever target FREE VCs and releases only change
    // BUSY VCs, so set and clear never collide on the same VC.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_gnt_ovc <= '0;
            r_errors  <= '0;
        end else begin
            r_busy    <= (r_busy & ~ovc_release) | w_ovc_won;
            for (int o = 0; o < NUM_OVCS; o++) begin
                if (w_ovc_won[o]) begin
                    r_ptr[o] <= f_next_ptr(w_offer_idx[o]);
                end
            end
            r_gnt     <= w_req_won;
            // Packed [req][ovc] flattens to bit r*NUM_OVCS + o.
            r_gnt_ovc <= w_accept;
            r_errors  <= {w_err_empty, w_err_release};
        end
    end

    assign gnt      = r_gnt;
    assign gnt_ovc  = r_gnt_ovc;
    assign ovc_busy = r_busy;
    assign errors   = r_errors;

endmodule
`default_nettype wire
